// File: rtl/trisc0_pkg.sv
// Shared definitions for the TRISC0 fetch/decode sequencer.
//   - opcode field width and opcode map (flow-control codes plus pass-through range)
//   - fetch FSM state encoding
package trisc0_pkg;

    localparam int unsigned OpcWidth = 4;

    // Codes 0x0..OpPassLast are handed to execute unchanged.
    localparam logic [OpcWidth-1:0] OpPassLast = 4'h9;
    localparam logic [OpcWidth-1:0] OpJmp      = 4'hA;
    localparam logic [OpcWidth-1:0] OpJz       = 4'hB;
    localparam logic [OpcWidth-1:0] OpJnz      = 4'hC;
    localparam logic [OpcWidth-1:0] OpCall     = 4'hD;
    localparam logic [OpcWidth-1:0] OpRet      = 4'hE;
    localparam logic [OpcWidth-1:0] OpHalt     = 4'hF;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StHalt  = 2'd2
    } state_e;

endpackage

// File: rtl/trisc0_ret_stack.sv
// Return-address stack for the TRISC0 fetch unit.
// A push on a full stack overwrites the oldest entry (circular buffer); a pop on an
// empty stack is ignored. top is the most recently pushed, still-live entry.
// Ports:
//   clk, reset (sync, active low)
//   push, pop       : operation strobes (push has priority)
//   push_data       : return address to store
//   top             : current top-of-stack
//   empty, full     : occupancy flags
module trisc0_ret_stack #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PtrW = $clog2(STACK_DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic [PtrW:0]         count;

    assign rd_ptr = wr_ptr - 1'b1;
    assign top    = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == CntFull);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            // When full the write lands on the oldest slot, so occupancy stays put.
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            wr_ptr <= rd_ptr;
            count  <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy tracking decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trisc0_fetch.sv
// TRISC0 instruction fetch/decode sequencer.
// Drives the synchronous ROM address, decodes the returned word one cycle later,
// resolves JMP/JZ/JNZ/CALL/RET/HALT locally and presents all other instructions to
// execute as valid-qualified opcode/operand pairs.
// Ports:
//   clk, reset (sync, active low)
//   address/q   : ROM address out, ROM data in (q = rom[address of previous cycle])
//   stall       : execute cannot accept; replays the current fetch
//   zero        : accumulator-zero flag for JZ/JNZ
//   instr_valid, opcode, operand, instr_pc : presented instruction
//   halted, stack_err : sticky status flags
module trisc0_fetch
    import trisc0_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          q,
    input  logic                           stall,
    input  logic                           zero,
    output logic                           instr_valid,
    output logic [OpcWidth-1:0]            opcode,
    output logic [DATA_WIDTH-OpcWidth-1:0] operand,
    output logic [ADDR_WIDTH-1:0]          instr_pc,
    output logic                           halted,
    output logic                           stack_err
);

    localparam int unsigned OprWidth = DATA_WIDTH - OpcWidth;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc, pc_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  inflight_q, inflight_d;

    logic                  instr_valid_d;
    logic [OpcWidth-1:0]   opcode_d;
    logic [OprWidth-1:0]   operand_d;
    logic [ADDR_WIDTH-1:0] instr_pc_d;
    logic                  halted_d;
    logic                  stack_err_d;

    logic                  push, pop, st_empty, st_full;
    logic [ADDR_WIDTH-1:0] st_top;

    logic [OpcWidth-1:0]   q_opc;
    logic [OprWidth-1:0]   q_opr;
    logic [ADDR_WIDTH-1:0] target;

    assign q_opc  = q[DATA_WIDTH-1 -: OpcWidth];
    assign q_opr  = q[OprWidth-1:0];
    assign target = q_opr[ADDR_WIDTH-1:0];

    trisc0_ret_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ret_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(pc_q + 1'b1),
        .top      (st_top),
        .empty    (st_empty),
        .full     (st_full)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        inflight_d    = inflight_q;
        address       = pc;
        instr_valid_d = instr_valid;
        opcode_d      = opcode;
        operand_d     = operand;
        instr_pc_d    = instr_pc;
        halted_d      = halted;
        stack_err_d   = stack_err;
        push          = 1'b0;
        pop           = 1'b0;

        unique case (state_q)
            StRun: begin
                if (stall) begin
                    // Re-issue last address so the same word is on q next cycle.
                    address = pc_q;
                end else begin
                    pc_d          = pc + 1'b1;
                    inflight_d    = 1'b1;
                    instr_valid_d = 1'b0;
                    if (inflight_q) begin
                        if (q_opc <= OpPassLast) begin
                            instr_valid_d = 1'b1;
                            opcode_d      = q_opc;
                            operand_d     = q_opr;
                            instr_pc_d    = pc_q;
                        end else begin
                            case (q_opc)
                                OpJmp: begin
                                    pc_d    = target;
                                    state_d = StFlush;
                                end
                                OpJz: begin
                                    if (zero) begin
                                        pc_d    = target;
                                        state_d = StFlush;
                                    end
                                end
                                OpJnz: begin
                                    if (!zero) begin
                                        pc_d    = target;
                                        state_d = StFlush;
                                    end
                                end
                                OpCall: begin
                                    push    = 1'b1;
                                    pc_d    = target;
                                    state_d = StFlush;
                                    if (st_full) stack_err_d = 1'b1;
                                end
                                OpRet: begin
                                    state_d = StFlush;
                                    if (st_empty) begin
                                        pc_d        = '0;
                                        stack_err_d = 1'b1;
                                    end else begin
                                        pop  = 1'b1;
                                        pc_d = st_top;
                                    end
                                end
                                default: begin // OpHalt
                                    // pc already equals pc_q+1; freeze it there.
                                    pc_d       = pc;
                                    inflight_d = 1'b0;
                                    halted_d   = 1'b1;
                                    state_d    = StHalt;
                                end
                            endcase
                        end
                    end
                end
            end
            StFlush: begin
                // q holds the speculative pc_q+1 word; drop it and fetch the target.
                pc_d          = pc + 1'b1;
                inflight_d    = 1'b1;
                instr_valid_d = 1'b0;
                state_d       = StRun;
            end
            StHalt: begin
                inflight_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StRun;
            pc          <= '0;
            pc_q        <= '0;
            inflight_q  <= 1'b0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            operand     <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            pc_q        <= address;
            inflight_q  <= inflight_d;
            instr_valid <= instr_valid_d;
            opcode      <= opcode_d;
            operand     <= operand_d;
            instr_pc    <= instr_pc_d;
            halted      <= halted_d;
            stack_err   <= stack_err_d;
        end
    end

endmodule

// File: tb/tb_trisc0_fetch.sv
// Directed, scoreboard-based bench for trisc0_fetch. Expected instruction streams are
// pushed per program; every instruction accepted by execute (instr_valid && !stall)
// is popped and compared, including the cycle gap to the previous accepted one.
module tb_trisc0_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  address;
    logic [11:0] q;
    logic        stall;
    logic        zero;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic [7:0]  instr_pc;
    logic        halted;
    logic        stack_err;

    logic [11:0] rom [256];

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] opc;
        logic [7:0] opr;
        logic [7:0] gap; // 0 = do not check
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;

    trisc0_fetch #(
        .DATA_WIDTH (12),
        .ADDR_WIDTH (8),
        .STACK_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .q          (q),
        .stall      (stall),
        .zero       (zero),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .operand    (operand),
        .instr_pc   (instr_pc),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) q <= rom[address];

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [7:0] a, input logic [7:0] gap);
        exp_t e;
        logic [11:0] w;
        w = rom[a];
        e.pc  = a;
        e.opc = w[11:8];
        e.opr = w[7:0];
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Score the current cycle (outputs and stall as driven now), then advance a cycle.
    task automatic tick();
        exp_t e;
        if (!reset) begin
            last_acc = cyc;
        end else if (instr_valid && !stall && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_instr", {12'h0, instr_pc, opcode, operand}, {12'h0, e.pc, e.opc, e.opr});
            if (e.gap != 8'd0) check("sb_gap", cyc - last_acc, 32'(e.gap));
            last_acc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) rom[i] = {4'(i % 10), 8'(i)};
    endtask

    // Ends at the negedge where reset is released; address 0 issues on the next edge.
    task automatic start();
        reset = 1'b0;
        stall = 1'b0;
        zero  = 1'b0;
        ticks(2);
        check("rst_state", {1'b0, instr_valid, opcode, operand, instr_pc, halted, stack_err,
                            address}, 32'h0);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_addr(input logic [7:0] a, input int limit, input string tag);
        int n = 0;
        while (address !== a && n < limit) begin
            tick();
            n++;
        end
        check(tag, {24'h0, address}, {24'h0, a});
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        zero  = 1'b0;

        // Straight-line code from 0
        load_default();
        start();
        for (int i = 0; i < 6; i++) expect_pc(8'(i), (i == 0) ? 8'd0 : 8'd1);
        check("rel_addr", {24'h0, address}, 32'h0);
        tick();
        check("first_valid_early", {23'h0, instr_valid, address}, {23'h0, 1'b0, 8'h01});
        tick();
        check("first_valid", {23'h0, instr_valid, instr_pc}, {23'h0, 1'b1, 8'h00});
        drain("straight_drain");

        // JMP at 0x00 to 0x10
        load_default();
        rom[8'h00] = 12'hA10;
        start();
        expect_pc(8'h10, 8'd0);
        expect_pc(8'h11, 8'd1);
        expect_pc(8'h12, 8'd1);
        tick();
        check("jmp_addr1", {24'h0, address}, 32'h01);
        tick();
        check("jmp_addr2", {23'h0, instr_valid, address}, {23'h0, 1'b0, 8'h10});
        tick();
        check("jmp_addr3", {23'h0, instr_valid, address}, {23'h0, 1'b0, 8'h11});
        tick();
        check("jmp_first", {23'h0, instr_valid, instr_pc}, {23'h0, 1'b1, 8'h10});
        drain("jmp_drain");

        // JZ taken
        load_default();
        rom[8'h05] = 12'hB20;
        start();
        zero = 1'b1;
        for (int i = 0; i < 5; i++) expect_pc(8'(i), (i == 0) ? 8'd0 : 8'd1);
        expect_pc(8'h20, 8'd3);
        expect_pc(8'h21, 8'd1);
        drain("jz_taken_drain");

        // JZ not taken: no flush, no output slot for the branch
        load_default();
        rom[8'h05] = 12'hB20;
        start();
        for (int i = 0; i < 5; i++) expect_pc(8'(i), (i == 0) ? 8'd0 : 8'd1);
        expect_pc(8'h06, 8'd2);
        expect_pc(8'h07, 8'd1);
        drain("jz_not_taken_drain");

        // JNZ taken
        load_default();
        rom[8'h05] = 12'hC30;
        start();
        for (int i = 0; i < 5; i++) expect_pc(8'(i), (i == 0) ? 8'd0 : 8'd1);
        expect_pc(8'h30, 8'd3);
        drain("jnz_taken_drain");

        // Five nested CALLs into a 4-deep stack, then RETs and an underflowing RET
        load_default();
        rom[8'h01] = 12'hD10;
        rom[8'h10] = 12'hD20;
        rom[8'h20] = 12'hD30;
        rom[8'h30] = 12'hD40;
        rom[8'h40] = 12'hD50;
        rom[8'h51] = 12'hE00;
        rom[8'h42] = 12'hE00;
        rom[8'h32] = 12'hE00;
        rom[8'h22] = 12'hE00;
        rom[8'h12] = 12'hE00;
        start();
        expect_pc(8'h00, 8'd0);
        expect_pc(8'h50, 8'd11);
        expect_pc(8'h41, 8'd3);
        expect_pc(8'h31, 8'd3);
        expect_pc(8'h21, 8'd3);
        expect_pc(8'h11, 8'd3);
        expect_pc(8'h00, 8'd3);
        wait_addr(8'h40, 30, "call4_reach");
        check("call4_no_err", {31'h0, stack_err}, 32'h0);
        wait_addr(8'h50, 10, "call5_reach");
        check("call5_err", {31'h0, stack_err}, 32'h1);
        drain("callret_drain");
        check("ret_err_sticky", {31'h0, stack_err}, 32'h1);

        // Stall for 3 cycles while rom[7] is on q
        load_default();
        start();
        for (int i = 0; i < 6; i++) expect_pc(8'(i), (i == 0) ? 8'd0 : 8'd1);
        expect_pc(8'h06, 8'd4);
        expect_pc(8'h07, 8'd1);
        expect_pc(8'h08, 8'd1);
        expect_pc(8'h09, 8'd1);
        ticks(8);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", {15'h0, instr_valid, instr_pc, address},
                  {15'h0, 1'b1, 8'h06, 8'h07});
            tick();
        end
        stall = 1'b0;
        #1;
        check("stall_release_addr", {24'h0, address}, 32'h08);
        drain("stall_drain");

        // PC wrap through 0xFF, then HALT at 0x02
        load_default();
        rom[8'h00] = 12'hCFC;
        rom[8'h02] = 12'hF00;
        start();
        expect_pc(8'hFC, 8'd0);
        expect_pc(8'hFD, 8'd1);
        expect_pc(8'hFE, 8'd1);
        expect_pc(8'hFF, 8'd1);
        expect_pc(8'h01, 8'd2);
        wait_addr(8'hFD, 10, "wrap_reach");
        zero = 1'b1;
        begin
            int n = 0;
            while (!halted && n < 40) begin
                tick();
                n++;
            end
        end
        check("halt_set", {31'h0, halted}, 32'h1);
        check("halt_addr", {24'h0, address}, 32'h03);
        ticks(3);
        check("halt_frozen", {22'h0, instr_valid, halted, address}, {22'h0, 1'b0, 1'b1, 8'h03});
        drain("halt_drain");

        // Reset out of HALT clears everything
        start();
        ticks(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trisc0_fetch.md
# trisc0_fetch

Instruction fetch/decode sequencer for the TRISC0 core. It sits directly downstream of the synchronous program ROM. It drives the ROM address and consumes the registered instruction word one cycle later. It resolves control flow (JMP/JZ/JNZ/CALL/RET/HALT) locally using a small return-address stack, and hands all other instructions to the execute stage as valid-qualified opcode/operand pairs.

## Interface
- DATA_WIDTH, 12: instruction width. Opcode is bits [DATA_WIDTH-1 -: 4]; operand is the remaining DATA_WIDTH-4 bits.
- ADDR_WIDTH, 8: program address width. Must be ≤ DATA_WIDTH-4.
- STACK_DEPTH, 4: return-stack entries, power of two.

Ports:
- clk, in, 1: system clock, the single clock domain.
- reset, in, 1: synchronous, active-low reset, sampled on rising clk.
- address, out, ADDR_WIDTH: ROM address.
- q, in, DATA_WIDTH: ROM data. It equals rom[address of previous cycle].
- stall, in, 1: execute stage cannot accept an instruction this cycle.
- zero, in, 1: accumulator-zero flag. Must be valid in the cycle a JZ/JNZ is on q.
- instr_valid, out, 1: opcode/operand/instr_pc hold a non-flow instruction for execute.
- opcode, out, 4: decoded opcode.
- operand, out, DATA_WIDTH-4: immediate/address field.
- instr_pc, out, ADDR_WIDTH: address of the presented instruction.
- halted, out, 1: HALT executed. Sticky until reset.
- stack_err, out, 1: sticky flag, set on return-stack overflow or underflow.

## Operation
- Opcode map (shared package):
  - 0xA JMP
  - 0xB JZ
  - 0xC JNZ
  - 0xD CALL
  - 0xE RET
  - 0xF HALT
  - 0x0–0x9: pass-through to execute.
- Jump target: operand[ADDR_WIDTH-1:0].
- Internal registers:
  - pc: next address to issue.
  - pc_q: address issued last cycle, i.e. the address whose data is now on q.
  - inflight: q holds a live, non-squashed word.
  - state ∈ {RUN, FLUSH, HALT}.
- RUN: address = pc; each non-stalled cycle sets pc ← pc+1, modulo 2^ADDR_WIDTH, so 0xFF wraps to 0x00. When inflight, q is decoded as follows:
  - Pass-through: registered to the outputs with instr_valid=1 next cycle.
  - JMP, JZ with zero=1, JNZ with zero=0: pc ← target; go to FLUSH. instr_valid=0 next cycle.
  - JZ/JNZ not taken: no output (instr_valid=0 next cycle); fetch continues.
  - CALL: push pc_q+1; pc ← target; go to FLUSH.
  - RET: pop into pc; go to FLUSH. On an empty stack: pc ← 0 and stack_err ← 1.
  - CALL on a full stack: overwrite the oldest entry (circular) and set stack_err ← 1.
  - HALT: go to HALT. address stays at pc_q+1. instr_valid=0.
- FLUSH, exactly 1 cycle: the word on q is the speculative pc_q+1 fetch. Discard it, issue address = new pc, return to RUN.
- HALT: no fetch advance and no outputs. Exit only via reset.
- Stall, when stall=1 while in RUN:
  - Outputs hold their current values.
  - pc holds.
  - address = pc_q, a replay so q presents the same word again next cycle.
  - The word on q is not decoded.
- When stall falls, decoding resumes from the replayed q. No instruction is lost or duplicated.
- Stall is ignored in FLUSH and HALT.

## Timing
- Reset (reset=0 at a clk edge):
  - pc=0, pc_q=0, address=0.
  - inflight=0, state=RUN.
  - instr_valid=0, opcode=0, operand=0, instr_pc=0.
  - halted=0, stack_err=0, stack emptied.
- Reset takes priority over every other event, including mid-FLUSH, mid-stall, and HALT.
- First edge after reset release: address 0 is issued. rom[0] is on q in the next cycle. Its instr_valid is high in the following cycle.
- Latency: address issue → instr_valid = 2 cycles.
- Throughput: 1 instruction per cycle for straight-line code.
- Taken branch, CALL, or RET: 1 bubble cycle (FLUSH). Not-taken branch: 0 bubbles, but no output slot is produced for it.
- The ROM word present on q in the cycle of reset release is ignored (inflight=0).
- Simultaneous CALL on a full stack: push and the stack_err set happen in the same edge.
- Simultaneous stall with HALT on q: stall wins. HALT is decoded when stall clears.

## Structure
- Package trisc0_pkg holds:
  - opcode localparams (JMP…HALT plus the pass-through codes);
  - state encoding {RUN, FLUSH, HALT};
  - the opcode field width (4).
- One sub-module: trisc0_ret_stack.
  - Parameters: STACK_DEPTH, ADDR_WIDTH.
  - Ports: push, pop, push_data, top, empty, full.
  - Synchronous active-low reset.
  - Circular buffer on overflow.
- Everything else (PC, FSM, decode, output registers) lives in trisc0_fetch.

## Test plan
- Straight-line: ROM 0x000..0x003 pass-through, program starts at 0.
  - Required: instr_pc 0,1,2,3 on consecutive cycles.
  - Required: first instr_valid 2 cycles after reset release.
- JMP: 0x00 = 0xA10.
  - Required: address sequence 0,1,0x10,0x11.
  - Required: the word at 0x01 is never presented.
  - Required: one instr_valid=0 bubble.
- JZ: 0x05 = 0xB20.
  - zero=1 → next presented instr_pc=0x20.
  - zero=0 → next presented instr_pc=0x06, with no bubble.
- CALL/RET: five nested CALLs with depth 4.
  - Required: stack_err=1 at the fifth CALL.
  - Required: the RETs return 0x..+1 addresses in LIFO order.
  - Required: a RET on an empty stack jumps to 0x00.
- Stall: assert stall for 3 cycles while 0x07 is on q.
  - Required: address shows the replay of 0x07.
  - Required: outputs held.
  - Required: after release, instr_pc 0x07 then 0x08, with no gap or duplicate.
- Wrap/HALT: PC runs through 0xFF → 0x00. A HALT at 0x02 sets halted=1 and freezes address at 0x03. reset=0 then clears everything.
